regfile_writeback: RTL
======================

// Module: regfile_writeback
// PURPOSE
//  Writer side of the 32-entry register file: accepts results from EXU (ALU/CSR) and LSU
//  (load data, arbitrary delay) over valid/ready, merges them into the single rf write port
//  (rf_wen/rf_waddr/rf_wdata), and keeps a per-register busy scoreboard for IDU hazard checks.
//  Sits between EXU/LSU and the register file; also emits a commit pulse for difftest.
// PARAMETERS
//  XLEN  32  data width
//  NREG  32  number of architectural registers
//  AW    5   register index width, $clog2(NREG)
// PORTS
//  clk          in   1     clock
//  rst_n        in   1     asynchronous active-low reset
//  exu_valid    in   1     EXU result valid
//  exu_ready    out  1     EXU result accepted when valid&ready at posedge
//  exu_rd       in   AW    destination register
//  exu_data     in   XLEN  result
//  exu_pc       in   32    PC of producing instruction
//  lsu_valid    in   1     LSU load result valid
//  lsu_ready    out  1     LSU result accepted when valid&ready at posedge
//  lsu_rd       in   AW    destination register
//  lsu_data     in   XLEN  load data
//  lsu_pc       in   32    PC of producing instruction
//  rsv_valid    in   1     IDU reserves rsv_rd (instruction issued, result pending)
//  rsv_rd       in   AW    register being reserved
//  busy         out  NREG  busy[i]=1: write to x[i] pending
//  rf_wen       out  1     register file write enable (registered)
//  rf_waddr     out  AW    register file write index (registered)
//  rf_wdata     out  XLEN  register file write data (registered)
//  commit_valid out  1     one-cycle pulse per retired writeback (registered)
//  commit_pc    out  32    PC of retired instruction (registered)
// BEHAVIOUR
//  - Reset (async, rst_n=0): both hold slots empty, rf_wen=0, rf_waddr=0, rf_wdata=0,
//    commit_valid=0, commit_pc=0, busy=0, last_grant=EXU. Reset mid-transfer drops all pending results.
//  - Each source owns one hold slot {v,rd,data,pc}. Handshake at edge E0 loads the slot.
//  - Arbiter (combinational, cycle after E0): one slot pending -> grant it; both pending ->
//    grant the source NOT in last_grant (round-robin; after reset LSU wins first tie).
//  - Granted slot drives output regs at next edge E1: rf_wen=(rd!=0), rf_waddr=rd, rf_wdata=data,
//    commit_valid=1, commit_pc=pc; slot clears; last_grant updates. No grant -> rf_wen=0, commit_valid=0.
//  - Latency: accept edge E0 -> rf_wen high in cycle E1..E2 -> register file writes at E2. Min 2 edges.
//  - xx_ready = ~slot_v | granted(xx): a draining slot refills on the same edge (full throughput 1/cycle/source-shared).
//  - rd==0: handshake and commit happen normally, rf_wen stays 0, busy untouched.
//  - Scoreboard, evaluated per edge: set busy[rsv_rd] if rsv_valid && rsv_rd!=0; clear busy[rf_waddr] if rf_wen.
//    Same index set and clear on same edge -> set wins (busy stays 1). busy[0] is constant 0.
//  - Reserving an already-busy register keeps it busy (no counter; IDU must stall on busy before reserving).
//  - At most one rf write per cycle; results never reordered within a source; no result ever dropped
//    except by reset.
// STRUCTURE
//  - Package regfile_pkg: XLEN, NREG, AW localparams; typedef wb_req_t {rd,data,pc};
//    typedef enum logic {SRC_EXU, SRC_LSU} wb_src_e.
//  - Sub-module wb_hold_slot: one-entry valid/ready buffer with drain input; instantiated twice.
//  - Top: two wb_hold_slot, round-robin arbiter + last_grant flop, output regs, busy scoreboard.
// TESTING
//  - Reset: assert rst_n=0 mid-stream -> rf_wen=0, busy=0, exu_ready=lsu_ready=1 immediately.
//  - Single EXU: exu rd=5 data=32'hDEADBEEF pc=32'h80000000 at E0 -> rf_wen=1,waddr=5 cycle E1, commit_pc=32'h80000000.
//  - Tie: EXU rd=1 and LSU rd=2 same edge -> LSU written first, EXU next cycle; next tie goes to EXU.
//  - x0: LSU rd=0 data=32'h1234 -> commit_valid=1, rf_wen=0, busy[0]=0.
//  - Scoreboard: rsv rd=7 -> busy[7]=1; EXU rd=7 writes; rsv rd=7 on same edge as rf_wen waddr=7 -> busy[7] stays 1.
//  - Backpressure: EXU valid every cycle for 8 results, LSU idle -> 8 writes in order, one per cycle, none lost.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, writeback request type and source enum
package regfile_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic [31:0]     pc;
    } wb_req_t;

    typedef enum logic {
        SRC_EXU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/regfile_writeback_slot.sv
// rtl/regfile_writeback_slot.sv - one-entry valid/ready hold buffer that refills on the draining edge
module wb_hold_slot
    import regfile_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_valid,
    input  wb_req_t i_req,
    input  logic    i_drain,
    output logic    o_ready,
    output logic    o_valid,
    output wb_req_t o_req
);

    logic    r_v;
    wb_req_t r_req;

    assign o_ready = ~r_v | i_drain;
    assign o_valid = r_v;
    assign o_req   = r_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v   <= 1'b0;
            r_req <= '0;
        end else if (i_valid && o_ready) begin
            r_v   <= 1'b1;
            r_req <= i_req;
        end else if (i_drain) begin
            r_v   <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - merges EXU/LSU results onto the rf write port and tracks busy registers
module regfile_writeback
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exu_valid,
    output logic            exu_ready,
    input  logic [AW-1:0]   exu_rd,
    input  logic [XLEN-1:0] exu_data,
    input  logic [31:0]     exu_pc,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic [31:0]     lsu_pc,
    input  logic            rsv_valid,
    input  logic [AW-1:0]   rsv_rd,
    output logic [NREG-1:0] busy,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            commit_valid,
    output logic [31:0]     commit_pc
);

    wb_req_t w_exu_req, w_lsu_req;
    logic    w_exu_v, w_lsu_v;
    logic    w_grant_exu, w_grant_lsu;
    wb_req_t w_sel;

    wb_src_e         r_last_grant;
    logic            r_rf_wen;
    logic [AW-1:0]   r_rf_waddr;
    logic [XLEN-1:0] r_rf_wdata;
    logic            r_commit_valid;
    logic [31:0]     r_commit_pc;
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    wb_hold_slot u_exu_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (exu_valid),
        .i_req   ('{rd: exu_rd, data: exu_data, pc: exu_pc}),
        .i_drain (w_grant_exu),
        .o_ready (exu_ready),
        .o_valid (w_exu_v),
        .o_req   (w_exu_req)
    );

    wb_hold_slot u_lsu_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (lsu_valid),
        .i_req   ('{rd: lsu_rd, data: lsu_data, pc: lsu_pc}),
        .i_drain (w_grant_lsu),
        .o_ready (lsu_ready),
        .o_valid (w_lsu_v),
        .o_req   (w_lsu_req)
    );

    // On a tie the source that did not win last time goes first.
    assign w_grant_exu = w_exu_v & (~w_lsu_v | (r_last_grant == SRC_LSU));
    assign w_grant_lsu = w_lsu_v & (~w_exu_v | (r_last_grant == SRC_EXU));
    assign w_sel       = w_grant_lsu ? w_lsu_req : w_exu_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant   <= SRC_EXU;
            r_rf_wen       <= 1'b0;
            r_rf_waddr     <= '0;
            r_rf_wdata     <= '0;
            r_commit_valid <= 1'b0;
            r_commit_pc    <= '0;
        end else if (w_grant_exu || w_grant_lsu) begin
            r_last_grant   <= w_grant_lsu ? SRC_LSU : SRC_EXU;
            r_rf_wen       <= (w_sel.rd != '0);
            r_rf_waddr     <= w_sel.rd;
            r_rf_wdata     <= w_sel.data;
            r_commit_valid <= 1'b1;
            r_commit_pc    <= w_sel.pc;
        end else begin
            r_rf_wen       <= 1'b0;
            r_commit_valid <= 1'b0;
        end
    end

    // Set is applied after clear so a same-edge reserve of the retiring register keeps it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_rf_wen)
            w_busy_nxt[r_rf_waddr] = 1'b0;
        if (rsv_valid && (rsv_rd != '0))
            w_busy_nxt[rsv_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    assign busy         = r_busy;
    assign rf_wen       = r_rf_wen;
    assign rf_waddr     = r_rf_waddr;
    assign rf_wdata     = r_rf_wdata;
    assign commit_valid = r_commit_valid;
    assign commit_pc    = r_commit_pc;

endmodule
